// File: rtl/timer.sv
// Enable-gated delay timer: counts prescaled ticks while i_enable is high and flags o_done after DELAY_CYCLES ticks.
// Optional build macro TIMER_PULSE_EN selects periodic one-clock pulses instead of a sticky level.
module timer #(
    parameter int DELAY_CYCLES = 30,
    parameter int CNT_W        = 5,
    parameter int PRESCALE     = 1,
    parameter int PRE_W        = 8
) (
    input  logic i_clock,
    input  logic i_rst_n,
    input  logic i_enable,
    output logic o_done
);

    localparam logic [CNT_W-1:0] LP_DELAY = CNT_W'(DELAY_CYCLES);
`ifdef TIMER_PULSE_EN
    localparam logic [CNT_W-1:0] LP_LAST  = CNT_W'(DELAY_CYCLES - 1);
`endif

    logic [CNT_W-1:0] r_cnt;
    logic             w_tick;

    generate
        if (PRESCALE == 1) begin : g_no_pre
            assign w_tick = i_enable;
        end else begin : g_pre
            localparam logic [PRE_W-1:0] LP_PRE_LAST = PRE_W'(PRESCALE - 1);
            logic [PRE_W-1:0] r_pre;

            assign w_tick = i_enable && (r_pre == LP_PRE_LAST);

            always_ff @(posedge i_clock or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_pre <= '0;
                end else if (!i_enable || (r_pre == LP_PRE_LAST)) begin
                    r_pre <= '0;
                end else begin
                    r_pre <= r_pre + PRE_W'(1);
                end
            end
        end
    endgenerate

    always_ff @(posedge i_clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt  <= '0;
            o_done <= 1'b0;
        end else if (!i_enable) begin
            r_cnt  <= '0;
            o_done <= 1'b0;
        end else if (w_tick) begin
`ifdef TIMER_PULSE_EN
            if (r_cnt == LP_LAST) begin
                r_cnt  <= '0;
                o_done <= 1'b1;
            end else begin
                r_cnt  <= r_cnt + CNT_W'(1);
                o_done <= 1'b0;
            end
`else
            // saturate at the delay; o_done stays sticky once reached
            if (r_cnt < LP_DELAY) begin
                r_cnt  <= r_cnt + CNT_W'(1);
                o_done <= ((r_cnt + CNT_W'(1)) == LP_DELAY);
            end
`endif
        end else begin
`ifdef TIMER_PULSE_EN
            o_done <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_timer.sv
// Directed self-checking bench for timer: default instance plus a PRESCALE=4 instance.
module tb_timer;

    logic clk;
    logic rst_n;
    logic en;
    logic done;
    logic en4;
    logic done4;

    int n_tests;
    int n_fail;

    timer dut (
        .i_clock (clk),
        .i_rst_n (rst_n),
        .i_enable(en),
        .o_done  (done)
    );

    timer #(.DELAY_CYCLES(30), .CNT_W(5), .PRESCALE(4), .PRE_W(8)) dut4 (
        .i_clock (clk),
        .i_rst_n (rst_n),
        .i_enable(en4),
        .o_done  (done4)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    // advance one rising edge, land 1 ns after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        en    = 1'b0;
        en4   = 1'b0;
        #20;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async done=%b expected 0", done);
        end
        n_tests++;
        if (done4 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async_pre4 done=%b expected 0", done4);
        end
        en = 1'b1;
        step();
        step();
        n_tests++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold done=%b expected 0", done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b0;
        step();
    endtask

    task automatic test_level();
        en = 1'b1;
        for (int e = 1; e <= 40; e++) begin
            step();
            n_tests++;
            if (done !== (e >= 30)) begin
                n_fail++;
                $display("FAIL level_edge%0d done=%b expected %b", e, done, (e >= 30));
            end
        end
    endtask

    task automatic test_drop_enable();
        // done is high on entry
        en = 1'b0;
        step();
        n_tests++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_clear done=%b expected 0", done);
        end
        en = 1'b1;
        for (int e = 1; e <= 30; e++) begin
            step();
            n_tests++;
            if (done !== (e == 30)) begin
                n_fail++;
                $display("FAIL reenable_edge%0d done=%b expected %b", e, done, (e == 30));
            end
        end
        #20;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_from_done done=%b expected 0", done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b0;
        step();
    endtask

    task automatic test_short_pulse();
        en = 1'b1;
        for (int e = 1; e <= 10; e++) step();
        en = 1'b0;
        step();
        n_tests++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL short_pulse done=%b expected 0", done);
        end
        en = 1'b1;
        for (int e = 1; e <= 30; e++) begin
            step();
            n_tests++;
            if (done !== (e == 30)) begin
                n_fail++;
                $display("FAIL short_reen_edge%0d done=%b expected %b", e, done, (e == 30));
            end
        end
        en = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_count();
        en = 1'b1;
        for (int e = 1; e <= 20; e++) step();
        rst_n = 1'b0;
        step();
        step();
        n_tests++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_hold done=%b expected 0", done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 1; e <= 30; e++) begin
            step();
            n_tests++;
            if (done !== (e == 30)) begin
                n_fail++;
                $display("FAIL midreset_edge%0d done=%b expected %b", e, done, (e == 30));
            end
        end
        en = 1'b0;
        step();
    endtask

    task automatic test_pulse();
        en = 1'b1;
        for (int e = 1; e <= 95; e++) begin
            step();
            n_tests++;
            if (done !== ((e % 30) == 0)) begin
                n_fail++;
                $display("FAIL pulse_edge%0d done=%b expected %b", e, done, ((e % 30) == 0));
            end
        end
        en = 1'b0;
        step();
        n_tests++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL pulse_drop done=%b expected 0", done);
        end
    endtask

    task automatic test_prescale();
        logic exp;
        en4 = 1'b1;
        for (int e = 1; e <= 125; e++) begin
            step();
`ifdef TIMER_PULSE_EN
            exp = (e == 120);
`else
            exp = (e >= 120);
`endif
            n_tests++;
            if (done4 !== exp) begin
                n_fail++;
                $display("FAIL pre4_edge%0d done=%b expected %b", e, done4, exp);
            end
        end
        en4 = 1'b0;
        step();
        n_tests++;
        if (done4 !== 1'b0) begin
            n_fail++;
            $display("FAIL pre4_drop done=%b expected 0", done4);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
`ifdef TIMER_PULSE_EN
        test_pulse();
`else
        test_level();
        test_drop_enable();
        test_short_pulse();
        test_reset_mid_count();
`endif
        test_prescale();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
